mul_share_arbiter: RTL
======================

Name: mul_share_arbiter

Overview:
- Shares one sequential signed multiplier engine (level start, one-cycle done pulse, 2*DATA_W product) between NUM_REQ requesters on the pclk domain.
- Round-robin arbitration, valid/ready operand handshake per requester, tagged single-cycle response bus, watchdog abort on a hung engine.
- Sits between peripheral requesters (APB register blocks, DMA-fed filters) and the multiplier engine; only owner of the engine's start input.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, operand width; product is 2*DATA_W
- TIMEOUT, 300, max RUN cycles before abort (exceeds worst-case engine latency for DATA_W=8)
- ID_W, 2, response tag width, equals clog2(NUM_REQ)

Ports:
- pclk  in  1  clock
- preset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request; held with operands until accepted
- req_a  in  NUM_REQ*DATA_W  flattened multiplicands, slice i belongs to requester i
- req_b  in  NUM_REQ*DATA_W  flattened multipliers
- req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_id  out  ID_W  index of the requester the response belongs to
- rsp_product  out  2*DATA_W  signed product; 0 when rsp_err
- rsp_err  out  1  qualifies rsp_valid: watchdog abort
- mul_start  out  1  engine start level
- mul_a  out  DATA_W  latched multiplicand to engine
- mul_b  out  DATA_W  latched multiplier to engine
- mul_done  in  1  engine done pulse
- mul_product  in  2*DATA_W  engine result, valid in the mul_done cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (preset high at posedge): state IDLE, rr pointer 0, all outputs 0 (req_ready, rsp_*, mul_start, mul_a, mul_b, busy); reset mid-operation abandons the job with no response; the engine is not cleared by this block.
- States: IDLE, GRANT, RUN, RESP, COOL.
- IDLE: if any req_valid, select first set bit searching from rr pointer upward with wrap; register grant index g; go GRANT next cycle. Request at edge t -> req_ready[g] high in cycle t+1.
- GRANT (one cycle): req_ready = one-hot(g). If req_valid[g] high: latch req_a/req_b slice g into mul_a/mul_b, rr pointer <= g+1 mod NUM_REQ, go RUN. If req_valid[g] dropped: no transfer, pointer unchanged, back to IDLE.
- RUN: mul_start=1; watchdog counts from 0. On mul_done: capture mul_product, mul_start low the next cycle, go RESP. If count reaches TIMEOUT-1 without mul_done: go RESP with error flag set.
- RESP (one cycle): rsp_valid=1, rsp_id=g, rsp_product=captured value (0 on error), rsp_err=flag; go COOL.
- COOL (one cycle): mul_start low, lets the engine return to idle before the next start; go IDLE. Back-to-back jobs have a minimum of 2 idle-start cycles between them.
- mul_done outside RUN is ignored. mul_done in the same cycle the watchdog expires counts as success.
- Width: product passed through unmodified (signed two's complement); zero and -128 operands not special-cased.
- req_ready is never high for more than one requester or outside GRANT; rsp_* outputs are 0 when rsp_valid is low.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 jobs.

Decomposition:
- Shared package mul_share_pkg: state enum (IDLE, GRANT, RUN, RESP, COOL) and default TIMEOUT constant.
- One sub-module rr_arbiter (NUM_REQ request vector + pointer -> grant index, any_req); FSM, watchdog and datapath stay in the top.

Test Plan:
- Single request: req 0 with a=8'h05, b=8'hFD, engine model returns 16'hFFF1 -> rsp_valid, rsp_id=0, rsp_product=16'hFFF1, rsp_err=0; req_ready[0] exactly one cycle, one cycle after req_valid rise.
- Round robin: all four ports request continuously from reset -> grant order 0,1,2,3,0; each response id matches its operands (port i: a=i+1, b=2 -> product 2*(i+1)).
- Withdrawn request: port 2 drops req_valid in GRANT cycle -> no mul_start, back to IDLE, next grant still searches from the unchanged pointer.
- Watchdog: engine model never pulses done -> after 300 RUN cycles rsp_valid with rsp_err=1, rsp_product=0; mul_start low afterwards; next job serviced normally.
- Reset mid-RUN: preset high during RUN -> next cycle mul_start=0, busy=0, no rsp_valid; pointer back to 0.
- Spurious done: mul_done pulsed in IDLE and COOL -> no response, state unaffected; done coincident with watchdog expiry -> rsp_err=0 with valid product.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mul_share_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    RUN,
    RESP,
    COOL
  } state_t;

  // Comfortably above the worst-case engine latency for 8-bit operands.
  localparam int DEFAULT_TIMEOUT = 300;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  int unsigned idx;

  // Scan requests starting at the pointer; the first hit wins.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= 32'(NUM_REQ)) begin
        idx = idx - 32'(NUM_REQ);
      end
      if (!any_req && req[idx[ID_W-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one sequential signed multiplier between NUM_REQ requesters with
// round-robin arbitration, tagged responses and a watchdog on the engine.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ID_W    = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [2*DATA_W-1:0]   rsp_product,
  output logic                  rsp_err,
  output logic                  mul_start,
  output logic [DATA_W-1:0]     mul_a,
  output logic [DATA_W-1:0]     mul_b,
  input  logic                  mul_done,
  input  logic [2*DATA_W-1:0]   mul_product,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  PTR_LAST = ID_W'(NUM_REQ - 1);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     g;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic [CNT_W-1:0]    wd_cnt;
  logic                wd_done;
  logic [2*DATA_W-1:0] prod_q;
  logic                err_q;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  assign a_sel   = req_a[g*DATA_W +: DATA_W];
  assign b_sel   = req_b[g*DATA_W +: DATA_W];
  assign wd_done = (wd_cnt == WD_LAST);

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; all outputs decode from the current state only.
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    mul_start   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_id      = '0;
    rsp_product = '0;
    rsp_err     = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (arb_any) state_nxt = GRANT;
      end
      GRANT: begin
        req_ready[g] = 1'b1;
        state_nxt    = req_valid[g] ? RUN : IDLE;
      end
      RUN: begin
        mul_start = 1'b1;
        // A done arriving on the last watchdog cycle still counts as success.
        if (mul_done || wd_done) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_id      = g;
        rsp_product = prod_q;
        rsp_err     = err_q;
        state_nxt   = COOL;
      end
      COOL: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, operand latch, pointer advance, watchdog and result capture.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rr_ptr <= '0;
      g      <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      wd_cnt <= '0;
      prod_q <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_any) g <= arb_idx;
        end
        GRANT: begin
          if (req_valid[g]) begin
            mul_a  <= a_sel;
            mul_b  <= b_sel;
            rr_ptr <= (g == PTR_LAST) ? '0 : g + 1'b1;
            wd_cnt <= '0;
          end
        end
        RUN: begin
          if (mul_done) begin
            prod_q <= mul_product;
            err_q  <= 1'b0;
          end else if (wd_done) begin
            prod_q <= '0;
            err_q  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
